kernel_buffer_pingpong: RTL and testbench

- Parametrised KSIZE x KSIZE convolution-weight store. Holds DEPTH kernels of WIDTH-bit weights in each of two banks: active and shadow.
- AXI-Stream slave input. Weights always load into the shadow bank. The active bank drives all KSIZE*KSIZE taps of the selected kernel in parallel.
- A swap request exchanges the banks, so the conv datapath reads one weight set while the next one streams in.
- Sits between the weight DMA stream and the conv MAC array.

---
 rtl/kernel_buffer_pingpong_if.sv | 32 +++
 rtl/kernel_buffer_pingpong.sv | 126 ++++++++++++
 tb/tb_kernel_buffer_pingpong.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/kernel_buffer_pingpong_if.sv
// Bundle of the weight-stream, bank-control and tap-output signals of the ping-pong kernel buffer.
// The buffer is the slave: it consumes the AXIS words and swap requests, and drives taps and status.
interface kernel_buffer_pingpong_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int KSIZE = 3
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TAPS  = KSIZE * KSIZE;

    logic                    i_tvalid;
    logic                    o_tready;
    logic [WIDTH-1:0]        i_tdata;
    logic                    i_tlast;
    logic [SEL_W-1:0]        i_sel;
    logic                    i_swap;
    logic                    o_load_done;
    logic                    o_active_bank;
    logic                    o_buf_valid;
    logic [TAPS*WIDTH-1:0]   o_buf;
    logic                    o_tlast_err;

    modport slave (
        input  i_tvalid, i_tdata, i_tlast, i_sel, i_swap,
        output o_tready, o_load_done, o_active_bank, o_buf_valid, o_buf, o_tlast_err
    );

    modport master (
        output i_tvalid, i_tdata, i_tlast, i_sel, i_swap,
        input  o_tready, o_load_done, o_active_bank, o_buf_valid, o_buf, o_tlast_err
    );
endinterface

// File: rtl/kernel_buffer_pingpong.sv
// Ping-pong KxK weight store: AXIS loads the shadow bank, the active bank drives every tap; o_buf 1-cycle latency.
// Backpressure: o_tready drops once the shadow bank is full and stays low until a swap promotes it.
module kernel_buffer_pingpong #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int KSIZE = 3
) (
    input  logic                     i_aclk,
    input  logic                     i_aresetn,
    kernel_buffer_pingpong_if.slave  s
);
    localparam int KK     = KSIZE * KSIZE;
    localparam int N      = DEPTH * KK;
    localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
    localparam int SEL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {ST_LOAD, ST_FULL} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic                   tready_q;
    logic                   load_done_q;
    logic                   active_q;
    logic                   buf_valid_q;
    logic [KK*WIDTH-1:0]    buf_q;
    logic                   err_q;

    logic                   xfer;
    logic                   last_word;
    logic                   err_set;
    logic                   swap_do;
    logic                   active_d;
    logic                   buf_valid_d;
    logic [KK*WIDTH-1:0]    rd_kernel;

    // Flop storage: all taps of a kernel are read in the same cycle.
    logic [1:0][N-1:0][WIDTH-1:0] bank_q;

    assign xfer        = s.i_tvalid & tready_q;
    assign last_word   = (cnt_q == ADDR_W'(N - 1));
    assign active_d    = active_q ^ swap_do;
    assign buf_valid_d = buf_valid_q | swap_do;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        swap_do = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (xfer) begin
                    if (last_word && s.i_tlast) begin
                        state_d = ST_FULL;
                        cnt_d   = '0;
                    end else if (last_word || s.i_tlast) begin
                        // Misplaced or missing TLAST: drop the partial load and restart.
                        err_set = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (s.i_swap) begin
                    swap_do = 1'b1;
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            tready_q    <= 1'b0;
            load_done_q <= 1'b0;
            active_q    <= 1'b0;
            buf_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tready_q    <= (state_d == ST_LOAD);
            load_done_q <= (state_d == ST_FULL);
            active_q    <= active_d;
            buf_valid_q <= buf_valid_d;
            err_q       <= err_q | err_set;
        end
    end

    // Shadow bank only; the active bank is never written.
    always_ff @(posedge i_aclk) begin
        if (xfer) begin
            bank_q[~active_q][cnt_q] <= s.i_tdata;
        end
    end

    // Read from the post-swap bank so the swap edge already shows the new weights.
    always_comb begin
        rd_kernel = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (s.i_sel == SEL_W'(k)) begin
                rd_kernel = bank_q[active_d][k*KK +: KK];
            end
        end
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_valid_d ? rd_kernel : '0;
        end
    end

    assign s.o_tready      = tready_q;
    assign s.o_load_done   = load_done_q;
    assign s.o_active_bank = active_q;
    assign s.o_buf_valid   = buf_valid_q;
    assign s.o_buf         = buf_q;
    assign s.o_tlast_err   = err_q;
endmodule

// File: tb/tb_kernel_buffer_pingpong.sv
// Directed bench for the ping-pong kernel buffer: table-driven read sweep plus hand-written load/swap/reset sequences.
module tb_kernel_buffer_pingpong;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    kernel_buffer_pingpong_if #(.WIDTH(8), .DEPTH(8), .KSIZE(3)) bus ();

    kernel_buffer_pingpong #(.WIDTH(8), .DEPTH(8), .KSIZE(3)) dut (
        .i_aclk    (aclk),
        .i_aresetn (aresetn),
        .s         (bus)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [2:0] sel;
        int         base;
    } rd_vec_t;

    rd_vec_t tbl [8];

    function automatic logic [71:0] taps(input int base);
        logic [71:0] r;
        r = '0;
        for (int t = 0; t < 9; t++) r[t*8 +: 8] = 8'(base + t);
        return r;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input int d, input logic last);
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = 8'(d);
        bus.i_tlast  = last;
        tick();
        bus.i_tvalid = 1'b0;
        bus.i_tlast  = 1'b0;
    endtask

    task automatic load_full(input int base);
        for (int n = 0; n < 72; n++) send(base + n, (n == 71));
    endtask

    task automatic do_swap();
        bus.i_swap = 1'b1;
        tick();
        bus.i_swap = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i].sel  = 3'(i);
            tbl[i].base = i * 9;
        end
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = '0;
        bus.i_tlast  = 1'b0;
        bus.i_sel    = '0;
        bus.i_swap   = 1'b0;

        // 1. reset defaults
        repeat (3) tick();
        aresetn = 1'b1;
        tick();
        chk1("rst_tready", bus.o_tready, 1'b1);
        chk1("rst_buf_valid", bus.o_buf_valid, 1'b0);
        chkb("rst_buf", bus.o_buf, 72'h0);
        chk1("rst_active", bus.o_active_bank, 1'b0);
        chk1("rst_load_done", bus.o_load_done, 1'b0);
        chk1("rst_err", bus.o_tlast_err, 1'b0);

        // 2. first load 0..71, swap, read sweep
        for (int n = 0; n < 71; n++) send(n, 1'b0);
        chk1("l1_done_early", bus.o_load_done, 1'b0);
        chk1("l1_tready_early", bus.o_tready, 1'b1);
        send(71, 1'b1);
        chk1("l1_tready_full", bus.o_tready, 1'b0);
        chk1("l1_done", bus.o_load_done, 1'b1);
        chk1("l1_active", bus.o_active_bank, 1'b0);
        chk1("l1_valid", bus.o_buf_valid, 1'b0);
        send(8'hEE, 1'b1);
        chk1("full_ignore_err", bus.o_tlast_err, 1'b0);
        chk1("full_ignore_done", bus.o_load_done, 1'b1);
        bus.i_sel = 3'd0;
        do_swap();
        chk1("sw1_active", bus.o_active_bank, 1'b1);
        chk1("sw1_valid", bus.o_buf_valid, 1'b1);
        chkb("sw1_buf", bus.o_buf, taps(0));
        chk1("sw1_done", bus.o_load_done, 1'b0);
        chk1("sw1_tready", bus.o_tready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            bus.i_sel = tbl[i].sel;
            tick();
            chkb($sformatf("tbl_sel%0d", i), bus.o_buf, taps(tbl[i].base));
        end
        chkb("sel7_literal", bus.o_buf, 72'h47464544434241403f);

        // 3. load 100..171 into shadow while sweeping the active bank
        for (int n = 0; n < 72; n++) begin
            bus.i_sel = 3'(n % 8);
            send(100 + n, (n == 71));
            chkb($sformatf("stable_w%0d", n), bus.o_buf, taps((n % 8) * 9));
        end
        bus.i_sel = 3'd2;
        do_swap();
        chk1("sw2_active", bus.o_active_bank, 1'b0);
        chkb("sw2_buf", bus.o_buf, taps(118));

        // 4. swaps during LOAD and coincident with the final word are ignored
        for (int n = 0; n < 72; n++) begin
            bus.i_swap = (n == 40 || n == 71);
            send(200 + n, (n == 71));
            bus.i_swap = 1'b0;
            if (n == 40) chk1("swmid_active", bus.o_active_bank, 1'b0);
            if (n == 70) chk1("swmid_done_early", bus.o_load_done, 1'b0);
        end
        chk1("swlast_active", bus.o_active_bank, 1'b0);
        chk1("swlast_done", bus.o_load_done, 1'b1);
        tick();
        chk1("swlast_no_queue", bus.o_active_bank, 1'b0);
        bus.i_sel = 3'd0;
        do_swap();
        chk1("sw3_active", bus.o_active_bank, 1'b1);
        chkb("sw3_buf", bus.o_buf, taps(200));

        // 5. early TLAST then a clean reload; missing TLAST then a clean reload
        for (int n = 0; n < 10; n++) send(30 + n, (n == 9));
        chk1("early_err", bus.o_tlast_err, 1'b1);
        chk1("early_tready", bus.o_tready, 1'b1);
        chk1("early_done", bus.o_load_done, 1'b0);
        load_full(50);
        chk1("reload_done", bus.o_load_done, 1'b1);
        chk1("reload_err_sticky", bus.o_tlast_err, 1'b1);
        do_swap();
        chk1("sw4_active", bus.o_active_bank, 1'b0);
        chkb("sw4_buf", bus.o_buf, taps(50));
        for (int n = 0; n < 72; n++) send(80 + n, 1'b0);
        chk1("notlast_done", bus.o_load_done, 1'b0);
        chk1("notlast_tready", bus.o_tready, 1'b1);
        load_full(150);
        chk1("reload2_done", bus.o_load_done, 1'b1);
        bus.i_sel = 3'd1;
        do_swap();
        chk1("sw5_active", bus.o_active_bank, 1'b1);
        chkb("sw5_buf", bus.o_buf, taps(159));

        // 6. asynchronous reset in the middle of a load
        for (int n = 0; n < 30; n++) send(n, 1'b0);
        aresetn = 1'b0;
        #2;
        chk1("arst_active", bus.o_active_bank, 1'b0);
        chk1("arst_valid", bus.o_buf_valid, 1'b0);
        chkb("arst_buf", bus.o_buf, 72'h0);
        chk1("arst_done", bus.o_load_done, 1'b0);
        chk1("arst_err", bus.o_tlast_err, 1'b0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        chk1("rel_tready", bus.o_tready, 1'b1);
        chkb("rel_buf", bus.o_buf, 72'h0);
        load_full(10);
        chk1("post_done", bus.o_load_done, 1'b1);
        bus.i_sel = 3'd0;
        do_swap();
        chk1("post_active", bus.o_active_bank, 1'b1);
        chk1("post_valid", bus.o_buf_valid, 1'b1);
        chkb("post_buf", bus.o_buf, taps(10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
